core2wb_bridge: RTL and testbench

Parametrised bridge from the Aquila device I/O master port to a pipelined Wishbone B4 master. It replaces the fixed 2-bit-address, ack-only converter with several additions:
- a registered request/response state machine;
- parametrised address slicing;
- honoured `wb_stall_i`;
- error termination via `wb_err_i`;
- an optional bus-timeout watchdog.

It sits between the Aquila core's device port and any Wishbone slave (UART, GPIO, timers).

---
 rtl/core2wb_bridge.sv | 132 +++++++++++++
 tb/tb_core2wb_bridge.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core2wb_bridge.sv
// Aquila device-port to pipelined Wishbone B4 master bridge: one outstanding access,
// honours stall, terminates on ack/err; optional bus watchdog enabled by `WB_TIMEOUT_EN.
module core2wb_bridge #(
  parameter int XLEN           = 32,
  parameter int DW             = 32,
  parameter int AW             = 4,
  parameter int ADDR_LSB       = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              S_DEVICE_strobe_i,
  input  logic [XLEN-1:0]   S_DEVICE_addr_i,
  input  logic              S_DEVICE_rw_i,
  input  logic [XLEN/8-1:0] S_DEVICE_byte_enable_i,
  input  logic [XLEN-1:0]   S_DEVICE_data_i,
  output logic              S_DEVICE_data_ready_o,
  output logic [XLEN-1:0]   S_DEVICE_data_o,
  output logic              bus_error_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [AW-1:0]     wb_addr_o,
  output logic [DW-1:0]     wb_data_o,
  output logic [DW/8-1:0]   wb_sel_o,
  input  logic              wb_stall_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic [DW-1:0]     wb_data_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  if (DW != XLEN) begin : g_width_check
    $error("core2wb_bridge: DW must equal XLEN");
  end

  state_t state_q, state_d;
  logic   term;
  logic   timeout;
  logic   tmo_hit;
  logic   err_q;

  // Only the address slice reaches the bus; the rest is decoded upstream.
  logic unused_addr;
  assign unused_addr = ^S_DEVICE_addr_i;

`ifdef WB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_REQ || state_q == S_WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  // Counter reads N-1 during the N-th bus cycle, so cyc is held exactly TIMEOUT_CYCLES cycles.
  assign tmo_hit = (state_q == S_REQ || state_q == S_WAIT) &&
                   (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    term    = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      S_IDLE: if (S_DEVICE_strobe_i) state_d = S_REQ;
      S_REQ: begin
        if (!wb_stall_i) begin
          term    = wb_ack_i | wb_err_i;
          state_d = term ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        term = wb_ack_i | wb_err_i;
        if (term) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit && !term) begin
      timeout = 1'b1;
      state_d = S_RESP;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every datapath register is reset because all outputs must read 0 during reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_we_o         <= 1'b0;
      wb_addr_o       <= '0;
      wb_data_o       <= '0;
      wb_sel_o        <= '0;
      S_DEVICE_data_o <= '0;
      err_q           <= 1'b0;
    end else begin
      if (state_q == S_IDLE && S_DEVICE_strobe_i) begin
        wb_we_o   <= S_DEVICE_rw_i;
        wb_addr_o <= S_DEVICE_addr_i[ADDR_LSB +: AW];
        wb_data_o <= S_DEVICE_data_i;
        wb_sel_o  <= S_DEVICE_byte_enable_i;
      end
      if (term) begin
        err_q           <= wb_err_i;
        S_DEVICE_data_o <= (wb_err_i || wb_we_o) ? '0 : wb_data_i;
      end else if (timeout) begin
        err_q           <= 1'b1;
        S_DEVICE_data_o <= '1;
      end
    end
  end

  // Bus controls decode straight from the state register so reset drops them immediately.
  assign wb_cyc_o              = (state_q == S_REQ) || (state_q == S_WAIT);
  assign wb_stb_o              = (state_q == S_REQ);
  assign S_DEVICE_data_ready_o = (state_q == S_RESP);
  assign bus_error_o           = (state_q == S_RESP) && err_q;

endmodule

// File: tb/tb_core2wb_bridge.sv
// Directed bench for core2wb_bridge; drives and samples on the falling edge of clk_i.
module tb_core2wb_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        strobe;
  logic [31:0] addr;
  logic        rw;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        data_ready;
  logic [31:0] rdata;
  logic        bus_error;
  logic        cyc, stb, we;
  logic [3:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  sel;
  logic        stall, ack, err;
  logic [31:0] wb_rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  core2wb_bridge #(
    .XLEN(32), .DW(32), .AW(4), .ADDR_LSB(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .S_DEVICE_strobe_i      (strobe),
    .S_DEVICE_addr_i        (addr),
    .S_DEVICE_rw_i          (rw),
    .S_DEVICE_byte_enable_i (be),
    .S_DEVICE_data_i        (wdata),
    .S_DEVICE_data_ready_o  (data_ready),
    .S_DEVICE_data_o        (rdata),
    .bus_error_o            (bus_error),
    .wb_cyc_o               (cyc),
    .wb_stb_o               (stb),
    .wb_we_o                (we),
    .wb_addr_o              (wb_addr),
    .wb_data_o              (wb_wdata),
    .wb_sel_o               (sel),
    .wb_stall_i             (stall),
    .wb_ack_i               (ack),
    .wb_err_i               (err),
    .wb_data_i              (wb_rdata)
  );

  task automatic test_reset();
    rst_i = 1'b1; strobe = 0; addr = 0; rw = 0; be = 0; wdata = 0;
    stall = 0; ack = 0; err = 0; wb_rdata = 0;
    repeat (2) @(negedge clk_i);
    total_cnt++;
    if ({cyc, stb, we, data_ready, bus_error, wb_addr, sel, wb_wdata, rdata} !== '0)
      $display("FAIL reset_outputs: cyc=%b stb=%b we=%b rdy=%b err=%b addr=%h sel=%h wd=%h rd=%h, want all 0",
               cyc, stb, we, data_ready, bus_error, wb_addr, sel, wb_wdata, rdata);
    else pass_cnt++;
    rst_i = 1'b0;
  endtask

  task automatic test_read_no_stall();
    @(negedge clk_i); strobe = 1; addr = 32'h0000_100C; rw = 0; be = 4'hF; wdata = 0;
    @(negedge clk_i); strobe = 0;
    total_cnt++;
    if (!(cyc === 1 && stb === 1 && wb_addr === 4'd3 && we === 0))
      $display("FAIL read_req: cyc=%b stb=%b addr=%0d we=%b, want 1 1 3 0", cyc, stb, wb_addr, we);
    else pass_cnt++;
    @(negedge clk_i);
    total_cnt++;
    if (!(cyc === 1 && stb === 0 && data_ready === 0))
      $display("FAIL read_wait: cyc=%b stb=%b rdy=%b, want 1 0 0", cyc, stb, data_ready);
    else pass_cnt++;
    ack = 1; wb_rdata = 32'hA5A5_0001;
    @(negedge clk_i); ack = 0; wb_rdata = 0;
    total_cnt++;
    if (!(data_ready === 1 && rdata === 32'hA5A5_0001 && bus_error === 0 && cyc === 0))
      $display("FAIL read_resp: rdy=%b data=%h err=%b cyc=%b, want 1 a5a50001 0 0",
               data_ready, rdata, bus_error, cyc);
    else pass_cnt++;
    @(negedge clk_i);
    total_cnt++;
    if (!(data_ready === 0 && rdata === 32'hA5A5_0001))
      $display("FAIL read_hold: rdy=%b data=%h, want 0 a5a50001", data_ready, rdata);
    else pass_cnt++;
  endtask

  task automatic test_stalled_write();
    @(negedge clk_i); strobe = 1; addr = 32'h0000_0024; rw = 1; be = 4'b0011;
    wdata = 32'h1234_5678; stall = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i); strobe = 0; wdata = 32'hFFFF_FFFF; be = 4'hF;
      stall = (k < 4);
      total_cnt++;
      if (!(stb === 1 && we === 1 && wb_wdata === 32'h1234_5678 && sel === 4'b0011 && wb_addr === 4'd9))
        $display("FAIL write_stall_c%0d: stb=%b we=%b wd=%h sel=%b addr=%0d, want 1 1 12345678 0011 9",
                 k, stb, we, wb_wdata, sel, wb_addr);
      else pass_cnt++;
    end
    @(negedge clk_i);
    total_cnt++;
    if (!(cyc === 1 && stb === 0 && data_ready === 0))
      $display("FAIL write_wait: cyc=%b stb=%b rdy=%b, want 1 0 0", cyc, stb, data_ready);
    else pass_cnt++;
    ack = 1; wb_rdata = 32'hFFFF_0000;
    @(negedge clk_i); ack = 0; wb_rdata = 0;
    total_cnt++;
    if (!(data_ready === 1 && rdata === 32'h0 && bus_error === 0))
      $display("FAIL write_resp: rdy=%b data=%h err=%b, want 1 0 0", data_ready, rdata, bus_error);
    else pass_cnt++;
  endtask

  task automatic test_error();
    @(negedge clk_i); strobe = 1; addr = 32'h0000_0008; rw = 0; be = 4'hF;
    @(negedge clk_i); strobe = 0;
    ack = 1; err = 1; wb_rdata = 32'hDEAD_BEEF;
    @(negedge clk_i); ack = 0; err = 0; wb_rdata = 0;
    total_cnt++;
    if (!(data_ready === 1 && bus_error === 1 && rdata === 32'h0))
      $display("FAIL err_resp: rdy=%b err=%b data=%h, want 1 1 0", data_ready, bus_error, rdata);
    else pass_cnt++;
    @(negedge clk_i);
    total_cnt++;
    if (!(data_ready === 0 && bus_error === 0))
      $display("FAIL err_single_pulse: rdy=%b err=%b, want 0 0", data_ready, bus_error);
    else pass_cnt++;
    ack = 1; err = 1; wb_rdata = 32'h5555_5555;
    @(negedge clk_i); ack = 0; err = 0; wb_rdata = 0;
    @(negedge clk_i);
    total_cnt++;
    if (!(data_ready === 0 && cyc === 0 && bus_error === 0 && rdata === 32'h0))
      $display("FAIL stray_ack_idle: rdy=%b cyc=%b err=%b data=%h, want 0 0 0 0",
               data_ready, cyc, bus_error, rdata);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    @(negedge clk_i); strobe = 1; addr = 32'h0000_0004; rw = 0; be = 4'hF;
`ifdef WB_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i); strobe = 0;
      if (cyc !== 1'b1) break;
      n++;
    end
    total_cnt++;
    if (n !== 8) $display("FAIL timeout_len: cyc high %0d cycles, want 8", n);
    else pass_cnt++;
    total_cnt++;
    if (!(data_ready === 1 && rdata === 32'hFFFF_FFFF && bus_error === 1))
      $display("FAIL timeout_resp: rdy=%b data=%h err=%b, want 1 ffffffff 1", data_ready, rdata, bus_error);
    else pass_cnt++;
`else
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_i); strobe = 0;
      if (cyc === 1'b1) n++;
    end
    total_cnt++;
    if (n !== 1000) $display("FAIL no_timeout_len: cyc high %0d of 1000 cycles, want 1000", n);
    else pass_cnt++;
    ack = 1; wb_rdata = 32'h0BAD_F00D;
    @(negedge clk_i); ack = 0; wb_rdata = 0;
    total_cnt++;
    if (!(data_ready === 1 && rdata === 32'h0BAD_F00D && bus_error === 0))
      $display("FAIL no_timeout_resp: rdy=%b data=%h err=%b, want 1 0badf00d 0", data_ready, rdata, bus_error);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk_i); strobe = 1; addr = 32'h0000_0014; rw = 0; be = 4'hF;
    @(negedge clk_i); strobe = 0;
    @(negedge clk_i);
    total_cnt++;
    if (!(cyc === 1 && stb === 0))
      $display("FAIL rst_pre_wait: cyc=%b stb=%b, want 1 0", cyc, stb);
    else pass_cnt++;
    #1 rst_i = 1;
    #1;
    total_cnt++;
    if (!(cyc === 0 && stb === 0 && data_ready === 0))
      $display("FAIL rst_async_drop: cyc=%b stb=%b rdy=%b, want 0 0 0", cyc, stb, data_ready);
    else pass_cnt++;
    ack = 1; wb_rdata = 32'h3333_3333;
    @(negedge clk_i); rst_i = 0; ack = 0; wb_rdata = 0;
    @(negedge clk_i);
    total_cnt++;
    if (!(data_ready === 0 && cyc === 0 && rdata === 32'h0))
      $display("FAIL rst_no_ready: rdy=%b cyc=%b data=%h, want 0 0 0", data_ready, cyc, rdata);
    else pass_cnt++;
    strobe = 1; addr = 32'h0000_001C; rw = 0; be = 4'hF;
    @(negedge clk_i); strobe = 0;
    total_cnt++;
    if (!(stb === 1 && wb_addr === 4'd7))
      $display("FAIL rst_after_req: stb=%b addr=%0d, want 1 7", stb, wb_addr);
    else pass_cnt++;
    ack = 1; wb_rdata = 32'h7777_0007;
    @(negedge clk_i); ack = 0; wb_rdata = 0;
    total_cnt++;
    if (!(data_ready === 1 && rdata === 32'h7777_0007 && bus_error === 0))
      $display("FAIL rst_after_resp: rdy=%b data=%h err=%b, want 1 77770007 0", data_ready, rdata, bus_error);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd;
    logic [3:0]  exp_sel;
    for (int i = 0; i < 16; i++) begin
      exp_sel = 4'(i) ^ 4'hF;
      @(negedge clk_i); strobe = 1; rw = i[0]; addr = 32'h0000_0100 + 32'(i * 4);
      wdata = 32'hC0DE_0000 + 32'(i); be = exp_sel;
      @(negedge clk_i); strobe = 0;
      total_cnt++;
      if (!(stb === 1 && we === i[0] && wb_addr === 4'(i) && (i[0] == 0 ||
            (wb_wdata === 32'hC0DE_0000 + 32'(i) && sel === exp_sel))))
        $display("FAIL b2b_req_%0d: stb=%b we=%b addr=%0d wd=%h sel=%b", i, stb, we, wb_addr, wb_wdata, sel);
      else pass_cnt++;
      ack = 1; wb_rdata = 32'h1000_0000 + 32'(i);
      @(negedge clk_i); ack = 0; wb_rdata = 0;
      exp_rd = i[0] ? 32'h0 : 32'h1000_0000 + 32'(i);
      total_cnt++;
      if (!(data_ready === 1 && rdata === exp_rd && bus_error === 0))
        $display("FAIL b2b_resp_%0d: rdy=%b data=%h err=%b, want 1 %h 0", i, data_ready, rdata, bus_error, exp_rd);
      else pass_cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_no_stall();
    test_stalled_write();
    test_error();
    test_timeout();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
